// File: rtl/bp_pht_if.sv
`default_nettype none
// ============================================================================
// Module   : bp_pht_if
// Brief    : Lookup, update and SRAM-port bundle for the PHT scheduler.
// Revision : 1.0
// ============================================================================
interface bp_pht_if #(
    parameter int IDX_BITS = 10
);
    logic                lookup_req;
    logic [IDX_BITS-1:0] lookup_idx;
    logic                lookup_gnt;
    logic                pred_valid;
    logic                pred_taken;
    logic                upd_valid;
    logic [IDX_BITS-1:0] upd_idx;
    logic                upd_taken;
    logic                upd_ready;
    logic                sram_csb;
    logic                sram_web;
    logic [IDX_BITS-1:0] sram_addr;
    logic [1:0]          sram_wdata;
    logic [1:0]          sram_rdata;

    modport master (
        output lookup_req, lookup_idx, upd_valid, upd_idx, upd_taken, sram_rdata,
        input  lookup_gnt, pred_valid, pred_taken, upd_ready,
               sram_csb, sram_web, sram_addr, sram_wdata
    );

    modport slave (
        input  lookup_req, lookup_idx, upd_valid, upd_idx, upd_taken, sram_rdata,
        output lookup_gnt, pred_valid, pred_taken, upd_ready,
               sram_csb, sram_web, sram_addr, sram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/bp_pht_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bp_pht_scheduler
// Brief    : Single-port PHT SRAM scheduler: lookup/update arbitration,
//            in-order saturating-counter RMW, post-reset table sweep.
//            Optional macro BP_PHT_FWD_EN forwards queued outcomes to lookups.
// Revision : 1.0
// ============================================================================
module bp_pht_scheduler #(
    parameter int IDX_BITS = 10,
    parameter int DEPTH    = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    bp_pht_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] S_INIT   = 2'd0;
    localparam logic [1:0] S_IDLE   = 2'd1;
    localparam logic [1:0] S_RMW_RD = 2'd2;
    localparam logic [1:0] S_RMW_WR = 2'd3;

    localparam logic [1:0] c_WEAK_NT = 2'b01;

    logic [1:0]          r_state;
    logic [IDX_BITS-1:0] r_init_cnt;
    logic [IDX_BITS-1:0] r_fifo_idx [DEPTH];
    logic [DEPTH-1:0]    r_fifo_tk;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_pred_valid;
    logic                r_pred_hold;

    logic                w_full;
    logic                w_empty;
    logic                w_gnt;
    logic                w_push;
    logic                w_pop;
    logic [IDX_BITS-1:0] w_head_idx;
    logic                w_head_tk;
    logic [1:0]          w_cnt_new;
    logic                w_pred_src;

    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_head_idx = r_fifo_idx[r_rd_ptr];
    assign w_head_tk  = r_fifo_tk[r_rd_ptr];
    // Lookups win the port in IDLE unless the queue is full.
    assign w_gnt      = !rst && (r_state == S_IDLE) && bus.lookup_req && !w_full;
    assign w_push     = bus.upd_valid && bus.upd_ready;
    assign w_pop      = (r_state == S_RMW_WR);

    assign bus.lookup_gnt = w_gnt;
    assign bus.upd_ready  = !rst && (r_state != S_INIT) && !w_full;

    always_comb begin
        w_cnt_new = bus.sram_rdata;
        if (w_head_tk) begin
            if (bus.sram_rdata != 2'b11) w_cnt_new = bus.sram_rdata + 2'd1;
        end else begin
            if (bus.sram_rdata != 2'b00) w_cnt_new = bus.sram_rdata - 2'd1;
        end
    end

    always_comb begin
        bus.sram_csb   = 1'b1;
        bus.sram_web   = 1'b1;
        bus.sram_addr  = '0;
        bus.sram_wdata = '0;
        if (!rst) begin
            case (r_state)
                S_INIT: begin
                    bus.sram_csb   = 1'b0;
                    bus.sram_web   = 1'b0;
                    bus.sram_addr  = r_init_cnt;
                    bus.sram_wdata = c_WEAK_NT;
                end
                S_IDLE: begin
                    if (w_gnt) begin
                        bus.sram_csb  = 1'b0;
                        bus.sram_addr = bus.lookup_idx;
                    end else if (!w_empty) begin
                        bus.sram_csb  = 1'b0;
                        bus.sram_addr = w_head_idx;
                    end
                end
                S_RMW_RD: begin
                    bus.sram_csb   = 1'b0;
                    bus.sram_web   = 1'b0;
                    bus.sram_addr  = w_head_idx;
                    bus.sram_wdata = w_cnt_new;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_INIT;
            r_init_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (&r_init_cnt) r_state <= S_IDLE;
                end
                S_IDLE:   if (!w_gnt && !w_empty) r_state <= S_RMW_RD;
                S_RMW_RD: r_state <= S_RMW_WR;
                default:  r_state <= S_IDLE;
            endcase
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_idx[r_wr_ptr] <= bus.upd_idx;
            r_fifo_tk[r_wr_ptr]  <= bus.upd_taken;
        end
    end

`ifdef BP_PHT_FWD_EN
    logic w_fwd_hit;
    logic w_fwd_tk;
    logic r_fwd_hit;
    logic r_fwd_tk;

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        w_fwd_hit = 1'b0;
        w_fwd_tk  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < r_count) &&
                (r_fifo_idx[r_rd_ptr + PTR_W'(i)] == bus.lookup_idx)) begin
                w_fwd_hit = 1'b1;
                w_fwd_tk  = r_fifo_tk[r_rd_ptr + PTR_W'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fwd_hit <= 1'b0;
            r_fwd_tk  <= 1'b0;
        end else if (w_gnt) begin
            r_fwd_hit <= w_fwd_hit;
            r_fwd_tk  <= w_fwd_tk;
        end
    end

    assign w_pred_src = r_fwd_hit ? r_fwd_tk : bus.sram_rdata[1];
`else
    assign w_pred_src = bus.sram_rdata[1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pred_valid <= 1'b0;
            r_pred_hold  <= 1'b0;
        end else begin
            r_pred_valid <= w_gnt;
            r_pred_hold  <= bus.pred_taken;
        end
    end

    assign bus.pred_valid = r_pred_valid;
    assign bus.pred_taken = r_pred_valid ? w_pred_src : r_pred_hold;
endmodule
`default_nettype wire

// File: tb/tb_bp_pht_scheduler.sv
`default_nettype none
// Bench for bp_pht_scheduler: directed scenarios plus random traffic, checked
// against an in-order counter-table model and a port-schedule model.
module tb_bp_pht_scheduler;
    localparam int IDX_BITS = 4;
    localparam int DEPTH    = 4;
    localparam int N        = 1 << IDX_BITS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bp_pht_if #(.IDX_BITS(IDX_BITS)) bus ();

    bp_pht_scheduler #(.IDX_BITS(IDX_BITS), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural single-port SRAM, one-cycle read latency.
    logic [1:0] mem [N];
    always @(posedge clk) begin
        if (!bus.sram_csb) begin
            if (!bus.sram_web) mem[bus.sram_addr] <= bus.sram_wdata;
            else               bus.sram_rdata     <= mem[bus.sram_addr];
        end
    end

    typedef struct {
        logic [IDX_BITS-1:0] idx;
        logic                tk;
    } upd_t;

    upd_t q[$];
    int   ref_ctr [N];
    int   checks = 0;
    int   errors = 0;
    bit   in_init;
    int   init_idx;
    int   busy;
    bit   pend, exp_pred, last_pred;
    logic s_gnt, s_ready, s_predv, s_pred;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int c, input bit tk);
        if (tk) return (c == 3) ? 3 : c + 1;
        return (c == 0) ? 0 : c - 1;
    endfunction

    // One clock: sample at negedge, compare with the models, return at posedge+1.
    task automatic cycle();
        int   occ;
        bit   exp_gnt;
        upd_t h;
        @(negedge clk);
        s_gnt   = bus.lookup_gnt;
        s_ready = bus.upd_ready;
        s_predv = bus.pred_valid;
        s_pred  = bus.pred_taken;
        check("pred_valid", s_predv, pend);
        if (pend) begin
            check("pred_taken", s_pred, exp_pred);
            last_pred = exp_pred;
        end else begin
            check("pred_hold", s_pred, last_pred);
        end
        pend = 0;
        if (in_init) begin
            check("init_csb", bus.sram_csb, 0);
            check("init_web", bus.sram_web, 0);
            check("init_addr", bus.sram_addr, init_idx);
            check("init_wdata", bus.sram_wdata, 2'b01);
            check("init_gnt", s_gnt, 0);
            check("init_ready", s_ready, 0);
            init_idx++;
            if (init_idx == N) in_init = 0;
        end else begin
            occ = q.size() + ((busy == 1) ? 1 : 0);
            check("upd_ready", s_ready, occ < DEPTH);
            if (busy == 0) begin
                exp_gnt = bus.lookup_req && (occ < DEPTH);
                check("lookup_gnt", s_gnt, exp_gnt);
                if (exp_gnt) begin
                    check("lk_csb", bus.sram_csb, 0);
                    check("lk_web", bus.sram_web, 1);
                    check("lk_addr", bus.sram_addr, bus.lookup_idx);
                    exp_pred = (ref_ctr[bus.lookup_idx] >= 2);
`ifdef BP_PHT_FWD_EN
                    foreach (q[j]) if (q[j].idx == bus.lookup_idx) exp_pred = q[j].tk;
`endif
                    pend = 1;
                end else if (q.size() > 0) begin
                    check("hd_csb", bus.sram_csb, 0);
                    check("hd_web", bus.sram_web, 1);
                    check("hd_addr", bus.sram_addr, q[0].idx);
                    busy = 2;
                end else begin
                    check("idle_csb", bus.sram_csb, 1);
                end
            end else if (busy == 2) begin
                h = q.pop_front();
                check("rmw_gnt", s_gnt, 0);
                check("wr_csb", bus.sram_csb, 0);
                check("wr_web", bus.sram_web, 0);
                check("wr_addr", bus.sram_addr, h.idx);
                check("wr_data", bus.sram_wdata, sat(ref_ctr[h.idx], h.tk));
                ref_ctr[h.idx] = sat(ref_ctr[h.idx], h.tk);
                busy = 1;
            end else begin
                check("rmw_gnt", s_gnt, 0);
                check("wrdone_csb", bus.sram_csb, 1);
                busy = 0;
            end
            if (bus.upd_valid && s_ready) q.push_back('{idx: bus.upd_idx, tk: bus.upd_taken});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycles(input int n);
        rst = 1'b1;
        bus.lookup_req = 1'b0;
        bus.upd_valid  = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("rst_csb", bus.sram_csb, 1);
            check("rst_gnt", bus.lookup_gnt, 0);
            check("rst_ready", bus.upd_ready, 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        q.delete();
        busy = 0; pend = 0; last_pred = 0; in_init = 1; init_idx = 0;
        foreach (ref_ctr[i]) ref_ctr[i] = 1;
    endtask

    task automatic run_init();
        bus.lookup_req = 1'b1;
        bus.lookup_idx = 4'd5;
        for (int k = 0; k < N; k++) cycle();
        bus.lookup_req = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        bus.lookup_req = 1'b0;
        bus.upd_valid  = 1'b0;
        while ((q.size() != 0 || busy != 0) && k < 200) begin
            cycle();
            k++;
        end
        if (k >= 200) check("drain_timeout", q.size(), 0);
        cycle();
    endtask

    task automatic enqueue(input int idx, input bit tk);
        bus.upd_valid = 1'b1;
        bus.upd_idx   = IDX_BITS'(idx);
        bus.upd_taken = tk;
        cycle();
        bus.upd_valid = 1'b0;
    endtask

    task automatic lookup(input int idx);
        bus.lookup_req = 1'b1;
        bus.lookup_idx = IDX_BITS'(idx);
        cycle();
        bus.lookup_req = 1'b0;
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        bus.lookup_req = 0; bus.lookup_idx = 0;
        bus.upd_valid  = 0; bus.upd_idx = 0; bus.upd_taken = 0;
        reset_cycles(2);
        run_init();

        // First post-sweep lookup sees a weakly-not-taken counter.
        lookup(5);
        check("idx5_pred_valid", s_predv, 1);
        check("idx5_pred", s_pred, 0);

        // Two taken updates saturate toward strongly taken.
        enqueue(3, 1); drain();
        enqueue(3, 1); drain();
        lookup(3);
        check("idx3_taken_pred", s_pred, 1);
        check("idx3_mem", mem[3], 2'b11);
        enqueue(3, 0); drain();
        lookup(3);
        check("idx3_nt1_pred", s_pred, 1);
        enqueue(3, 0); drain();
        lookup(3);
        check("idx3_nt2_pred", s_pred, 0);
        for (int k = 0; k < 3; k++) begin enqueue(2, 0); drain(); end
        check("idx2_floor", mem[2], 2'b00);

        // Full queue starves a held lookup for the RMW window.
        bus.lookup_req = 1'b1;
        bus.lookup_idx = 4'd1;
        bus.upd_valid  = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            bus.upd_idx   = IDX_BITS'(8 + k);
            bus.upd_taken = 1'b1;
            cycle();
        end
        bus.upd_valid = 1'b0;
        cycle();
        check("full_ready", s_ready, 0);
        gap = s_gnt ? 0 : 1;
        for (int k = 0; k < 10 && !s_gnt; k++) begin
            cycle();
            if (!s_gnt) gap++;
        end
        check("starve_gap", gap, 3);
        check("resume_ready", s_ready, 1);
        drain();

        // Lookup of an index whose update is still queued.
        bus.lookup_req = 1'b1;
        bus.lookup_idx = 4'd7;
        bus.upd_valid  = 1'b1;
        bus.upd_idx    = 4'd7;
        bus.upd_taken  = 1'b1;
        cycle();
        bus.upd_valid = 1'b0;
        cycle();
        bus.lookup_req = 1'b0;
        cycle();
`ifdef BP_PHT_FWD_EN
        check("fwd_idx7", s_pred, 1);
`else
        check("fwd_idx7", s_pred, 0);
`endif
        drain();

        // Reset during RMW_RD with three entries queued.
        bus.lookup_req = 1'b1;
        bus.lookup_idx = 4'd0;
        for (int k = 0; k < 3; k++) enqueue(12 + k, 1);
        check("abort_qlen", q.size(), 3);
        bus.lookup_req = 1'b0;
        cycle();
        reset_cycles(1);
        run_init();
        for (int k = 0; k < 3; k++) cycle();
        check("abort_mem12", mem[12], 2'b01);

        // Random traffic.
        for (int k = 0; k < 2000; k++) begin
            bus.lookup_req = ($urandom_range(0, 99) < 60);
            bus.lookup_idx = IDX_BITS'($urandom_range(0, N - 1));
            bus.upd_valid  = ($urandom_range(0, 99) < 50);
            bus.upd_idx    = IDX_BITS'($urandom_range(0, N - 1));
            bus.upd_taken  = $urandom_range(0, 1);
            cycle();
        end
        drain();
        for (int i = 0; i < N; i++) begin
            lookup(i);
            check("final_mem", mem[i], ref_ctr[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
